// File: rtl/pattern_serializer.sv
// pattern_serializer
// Serial pattern source for the in/valid bit-stream interface. A PAT_W-bit word is
// loaded on start and shifted out MSB-first, one bit per valid cycle, repeated a
// programmed number of times with an optional idle gap between repetitions.
// Every output comes straight from a flop, so no input reaches an output in the
// same cycle. 'stall' freezes the whole machine and forces valid/out low.

module pattern_serializer #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap,
    input  logic             stall,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;     // latched word, used to reload between repeats
    logic [PAT_W-1:0] sr_q, sr_d;       // shifter, MSB is the next bit on the line
    logic [IDX_W-1:0] idx_q, idx_d;     // index of the bit currently at the shifter MSB
    logic [CNT_W-1:0] rem_q, rem_d;     // repetitions still to send, including the current one
    logic [CNT_W-1:0] gap_q, gap_d;     // latched gap length
    logic [CNT_W-1:0] gcnt_q, gcnt_d;   // idle cycles left in the current gap
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rem_dec_s;

    assign rem_dec_s = rem_q - CNT_ONE;

    // Next-state and next-output logic; stall holds every piece of state and idles the line.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (stall) begin
            // Frozen: only the line outputs change (forced idle above).
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pat_d  = pattern;
                        sr_d   = pattern;
                        rem_d  = repeat_cnt;
                        gap_d  = gap;
                        idx_d  = IDX_LAST;
                        gcnt_d = CNT_ZERO;
                        busy_d = 1'b1;
                        if (repeat_cnt == CNT_ZERO) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        busy_d = 1'b0;
                    end
                end

                ST_SHIFT: begin
                    out_d   = sr_q[PAT_W-1];
                    valid_d = 1'b1;
                    sr_d    = sr_q << 1;
                    if (idx_q == IDX_ZERO) begin
                        // Last bit of this word goes out now.
                        rem_d = rem_dec_s;
                        if (rem_dec_s == CNT_ZERO) begin
                            state_d = ST_DONE;
                        end else if (gap_q == CNT_ZERO) begin
                            sr_d  = pat_q;
                            idx_d = IDX_LAST;
                        end else begin
                            gcnt_d  = gap_q;
                            state_d = ST_GAP;
                        end
                    end else begin
                        idx_d = idx_q - IDX_ONE;
                    end
                end

                ST_GAP: begin
                    if (gcnt_q <= CNT_ONE) begin
                        gcnt_d  = CNT_ZERO;
                        sr_d    = pat_q;
                        idx_d   = IDX_LAST;
                        state_d = ST_SHIFT;
                    end else begin
                        gcnt_d = gcnt_q - CNT_ONE;
                    end
                end

                ST_DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end

                default: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= {PAT_W{1'b0}};
            sr_q    <= {PAT_W{1'b0}};
            idx_q   <= IDX_ZERO;
            rem_q   <= CNT_ZERO;
            gap_q   <= CNT_ZERO;
            gcnt_q  <= CNT_ZERO;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer. Each scenario starts a transmission,
// samples the outputs on the falling edge once per cycle and compares the
// collected bit streams against hand-written expected vectors (first sample in
// the MSB position, the sample taken right after the accepting edge).

module tb_pattern_serializer;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic [3:0] pattern_i;
    logic [7:0] repeat_i;
    logic [7:0] gap_i;
    logic       stall_i;
    logic       out_o;
    logic       valid_o;
    logic       busy_o;
    logic       done_o;

    int n_tests;
    int n_fail;

    logic [63:0] vv, ov, dv, bv;
    int          nval, nones, didx;
    logic        done_seen;

    pattern_serializer #(.PAT_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start_i),
        .pattern    (pattern_i),
        .repeat_cnt (repeat_i),
        .gap        (gap_i),
        .stall      (stall_i),
        .out        (out_o),
        .valid      (valid_o),
        .busy       (busy_o),
        .done       (done_o)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a start request so it is accepted on the next rising edge (edge k).
    task automatic do_start(input logic [3:0] pat, input logic [7:0] rep, input logic [7:0] gp);
        @(negedge clk);
        pattern_i = pat;
        repeat_i  = rep;
        gap_i     = gp;
        start_i   = 1'b1;
        @(posedge clk);
    endtask

    // Collect n samples (after edges k..k+n-1). Optional stall window or
    // repeated start requests while busy / in the done cycle.
    task automatic capture(input int n, input bit stall_mode, input bit restart_mode,
                           output logic [63:0] v_o, output logic [63:0] o_o,
                           output logic [63:0] d_o, output logic [63:0] b_o);
        v_o = '0; o_o = '0; d_o = '0; b_o = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) start_i = 1'b0;
            v_o = {v_o[62:0], valid_o};
            o_o = {o_o[62:0], out_o};
            d_o = {d_o[62:0], done_o};
            b_o = {b_o[62:0], busy_o};
            if (restart_mode) begin
                if (i >= 1 && i <= 4) begin
                    start_i   = 1'b1;
                    pattern_i = 4'b0100;
                    repeat_i  = 8'd5;
                    gap_i     = 8'd3;
                end else if (i == 5) begin
                    start_i = 1'b0;
                end
            end
            if (stall_mode) begin
                if (i == 2) stall_i = 1'b1;
                if (i == 5) stall_i = 1'b0;
            end
        end
    endtask

    // Run until done (bounded); count valid bits, ones, and the done sample index.
    task automatic run_count(input int budget, output int nv, output int n1, output int di);
        nv = 0; n1 = 0; di = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i == 0) start_i = 1'b0;
            if (valid_o) nv++;
            if (valid_o && out_o) n1++;
            if (done_o) begin
                di = i;
                break;
            end
        end
    endtask

    // Reference 1011 detector (overlapping) over the valid bits of a capture.
    function automatic int count_1011(input logic [63:0] v_i, input logic [63:0] o_i, input int n);
        logic [3:0] win;
        int cnt;
        int nb;
        win = 4'b0000; cnt = 0; nb = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (v_i[i]) begin
                win = {win[2:0], o_i[i]};
                nb++;
                if (nb >= 4 && win == 4'b1011) cnt++;
            end
        end
        return cnt;
    endfunction

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        start_i   = 1'b0;
        pattern_i = 4'b0000;
        repeat_i  = 8'd0;
        gap_i     = 8'd0;
        stall_i   = 1'b0;

        repeat (3) @(negedge clk);
        check_val("reset_outs", {60'd0, out_o, valid_o, busy_o, done_o}, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_outs", {60'd0, out_o, valid_o, busy_o, done_o}, 64'd0);

        // 1: single word
        do_start(4'b1011, 8'd1, 8'd0);
        capture(7, 1'b0, 1'b0, vv, ov, dv, bv);
        check_val("t1_valid", vv, 64'b0111100);
        check_val("t1_out",   ov, 64'b0101100);
        check_val("t1_done",  dv, 64'b0000010);
        check_val("t1_busy",  bv, 64'b1111100);

        // 2: three back-to-back words
        do_start(4'b1011, 8'd3, 8'd0);
        capture(15, 1'b0, 1'b0, vv, ov, dv, bv);
        check_val("t2_valid", vv, 64'b011111111111100);
        check_val("t2_out",   ov, 64'b010111011101100);
        check_val("t2_done",  dv, 64'b000000000000010);
        check_val("t2_detect", 64'(count_1011(vv, ov, 15)), 64'd3);
        check_val("t2_ndone", 64'($countones(dv)), 64'd1);

        // 3: two words with a two-cycle gap
        do_start(4'b1011, 8'd2, 8'd2);
        capture(13, 1'b0, 1'b0, vv, ov, dv, bv);
        check_val("t3_valid", vv, 64'b0111100111100);
        check_val("t3_out",   ov, 64'b0101100101100);
        check_val("t3_done",  dv, 64'b0000000000010);
        check_val("t3_busy",  bv, 64'b1111111111100);

        // 4: stall for three cycles after the second bit
        do_start(4'b1011, 8'd1, 8'd0);
        capture(10, 1'b1, 1'b0, vv, ov, dv, bv);
        check_val("t4_valid", vv, 64'b0110001100);
        check_val("t4_out",   ov, 64'b0100001100);
        check_val("t4_done",  dv, 64'b0000000010);
        check_val("t4_busy",  bv, 64'b1111111100);

        // 5a: zero repeats
        do_start(4'b1011, 8'd0, 8'd0);
        capture(3, 1'b0, 1'b0, vv, ov, dv, bv);
        check_val("t5_valid", vv, 64'b000);
        check_val("t5_done",  dv, 64'b010);
        check_val("t5_busy",  bv, 64'b100);

        // 5b: start re-asserted while busy and in the done cycle is ignored
        do_start(4'b1011, 8'd1, 8'd0);
        capture(8, 1'b0, 1'b1, vv, ov, dv, bv);
        check_val("t5b_valid", vv, 64'b01111000);
        check_val("t5b_out",   ov, 64'b01011000);
        check_val("t5b_done",  dv, 64'b00000100);
        check_val("t5b_busy",  bv, 64'b11111000);

        // 6: reset after the second bit
        do_start(4'b1011, 8'd1, 8'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("t6_bit2", {62'd0, valid_o, out_o}, 64'b10);
        rst = 1'b0;
        #1;
        check_val("t6_rst_outs", {61'd0, out_o, valid_o, busy_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            done_seen = done_seen | done_o | busy_o | valid_o;
        end
        check_val("t6_quiet", {63'd0, done_seen}, 64'd0);
        do_start(4'b1011, 8'd1, 8'd0);
        capture(7, 1'b0, 1'b0, vv, ov, dv, bv);
        check_val("t6_fresh_valid", vv, 64'b0111100);
        check_val("t6_fresh_out",   ov, 64'b0101100);
        check_val("t6_fresh_done",  dv, 64'b0000010);

        // Maximum repeat count, back-to-back
        do_start(4'b1011, 8'd255, 8'd0);
        run_count(2000, nval, nones, didx);
        check_val("max_rep_valid", 64'(nval), 64'd1020);
        check_val("max_rep_ones",  64'(nones), 64'd765);
        check_val("max_rep_done",  64'(didx), 64'd1021);

        // Maximum gap
        do_start(4'b1001, 8'd2, 8'd255);
        run_count(600, nval, nones, didx);
        check_val("max_gap_valid", 64'(nval), 64'd8);
        check_val("max_gap_ones",  64'(nones), 64'd4);
        check_val("max_gap_done",  64'(didx), 64'd264);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
